// File: rtl/axi_master_pkg.sv
// Shared types and AXI constants for the read-channel initiator and its beat tracker.
package axi_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int ERR_RESP_BIT  = 0;
    localparam int ERR_PROTO_BIT = 1;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_beat_tracker.sv
// Beat counter plus sticky error flags for one read burst; cleared when a new
// request is accepted and updated on every R handshake.
module axi_beat_tracker
    import axi_master_pkg::*;
#(
    parameter int LEN_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                beat_i,
    input  logic                last_i,
    input  logic                id_bad_i,
    input  logic                resp_err_i,
    input  logic [LEN_BITS-1:0] len_i,
    output logic [LEN_BITS-1:0] count_o,
    output logic [1:0]          err_o
);

    logic [LEN_BITS-1:0] count_q, count_d;
    logic [1:0]          err_q, err_d;
    logic                at_len;

    assign at_len = (count_q == len_i);

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        count_d = count_q;
        err_d   = err_q;
        if (clear_i) begin
            count_d = '0;
            err_d   = '0;
        end else if (beat_i) begin
            count_d = count_q + 1'b1;
            if (resp_err_i) begin
                err_d[ERR_RESP_BIT] = 1'b1;
            end
            // RLAST must coincide exactly with the beat numbered len: early or missing both flag.
            if (id_bad_i || (last_i != at_len)) begin
                err_d[ERR_PROTO_BIT] = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read-channel initiator: one outstanding burst, AR handshake, then R beats
// re-registered towards the client with a done pulse and error summary.
module axi_read_master
    import axi_master_pkg::*;
#(
    parameter int                 ID_BITS   = 4,
    parameter int                 ADDR_BITS = 32,
    parameter int                 DATA_BITS = 32,
    parameter int                 LEN_BITS  = 4,
    parameter logic [ID_BITS-1:0] MASTER_ID = '0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic                 beat_stall,
    output logic                 beat_valid,
    output logic [DATA_BITS-1:0] beat_data,
    output logic [LEN_BITS-1:0]  beat_idx,
    output logic                 done,
    output logic [1:0]           err_code,
    output logic [ID_BITS-1:0]   ARID_M,
    output logic [ADDR_BITS-1:0] ARADDR_M,
    output logic [LEN_BITS-1:0]  ARLEN_M,
    output logic [2:0]           ARSIZE_M,
    output logic [1:0]           ARBURST_M,
    output logic                 ARVALID_M,
    input  logic                 ARREADY_M,
    input  logic [ID_BITS-1:0]   RID_M,
    input  logic [DATA_BITS-1:0] RDATA_M,
    input  logic [1:0]           RRESP_M,
    input  logic                 RLAST_M,
    input  logic                 RVALID_M,
    output logic                 RREADY_M
);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic                   beat_valid_q, beat_valid_d;
    logic [DATA_BITS-1:0]   beat_data_q, beat_data_d;
    logic [LEN_BITS-1:0]    beat_idx_q, beat_idx_d;
    logic [LEN_BITS-1:0]    count;
    logic                   accept;
    logic                   r_hs;

    assign accept = (state_q == IDLE) && req_valid;
    assign r_hs   = (state_q == DATA) && RVALID_M && RREADY_M;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)          state_d = ADDR;
            ADDR:    if (ARREADY_M)          state_d = DATA;
            DATA:    if (r_hs && RLAST_M)    state_d = DONE;
            DONE:                            state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            ADDR:    ARVALID_M = 1'b1;
            DATA:    RREADY_M  = ~beat_stall;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        len_d        = len_q;
        beat_valid_d = r_hs;
        beat_data_d  = beat_data_q;
        beat_idx_d   = beat_idx_q;
        if (accept) begin
            addr_d = req_addr;
            len_d  = req_len;
        end
        if (r_hs) begin
            beat_data_d = RDATA_M;
            beat_idx_d  = count;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q       <= '0;
            len_q        <= '0;
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
            beat_idx_q   <= '0;
        end else begin
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_valid_q <= beat_valid_d;
            beat_data_q  <= beat_data_d;
            beat_idx_q   <= beat_idx_d;
        end
    end

    axi_beat_tracker #(
        .LEN_BITS (LEN_BITS)
    ) u_tracker (
        .clk        (ACLK),
        .rst        (ARESET),
        .clear_i    (accept),
        .beat_i     (r_hs),
        .last_i     (RLAST_M),
        .id_bad_i   (RID_M != MASTER_ID),
        .resp_err_i (resp_is_error(RRESP_M)),
        .len_i      (len_q),
        .count_o    (count),
        .err_o      (err_code)
    );

    assign beat_valid = beat_valid_q;
    assign beat_data  = beat_data_q;
    assign beat_idx   = beat_idx_q;
    assign ARID_M     = MASTER_ID;
    assign ARADDR_M   = addr_q;
    assign ARLEN_M    = len_q;
    assign ARSIZE_M   = 3'($clog2(DATA_BITS / 8));
    assign ARBURST_M  = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: table of bursts driven by a scripted AXI slave, with a
// beat scoreboard, plus hand-written reset sequences.
module tb_axi_read_master;
    import axi_master_pkg::*;

    localparam logic [3:0] MASTER_ID = 4'd0;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        beat_stall;
    logic        beat_valid;
    logic [31:0] beat_data;
    logic [3:0]  beat_idx;
    logic        done;
    logic [1:0]  err_code;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M;
    logic        RVALID_M;
    logic        RREADY_M;

    axi_read_master #(
        .ID_BITS   (4),
        .ADDR_BITS (32),
        .DATA_BITS (32),
        .LEN_BITS  (4),
        .MASTER_ID (MASTER_ID)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .beat_stall (beat_stall),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_idx   (beat_idx),
        .done       (done),
        .err_code   (err_code),
        .ARID_M     (ARID_M),
        .ARADDR_M   (ARADDR_M),
        .ARLEN_M    (ARLEN_M),
        .ARSIZE_M   (ARSIZE_M),
        .ARBURST_M  (ARBURST_M),
        .ARVALID_M  (ARVALID_M),
        .ARREADY_M  (ARREADY_M),
        .RID_M      (RID_M),
        .RDATA_M    (RDATA_M),
        .RRESP_M    (RRESP_M),
        .RLAST_M    (RLAST_M),
        .RVALID_M   (RVALID_M),
        .RREADY_M   (RREADY_M)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        int          ar_wait;      // cycles ARREADY stays low while ARVALID is up
        int          nbeats;       // RLAST is driven on beat nbeats-1
        logic [31:0] base;         // beat b carries base+b
        int          resp_beat;    // beat carrying resp_val, -1 for none
        logic [1:0]  resp_val;
        int          badid_beat;   // beat with RID = MASTER_ID+1, -1 for none
        int          stall_at;     // beat preceded by stall_cycles of beat_stall
        int          stall_cycles;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
    } beat_t;

    vec_t  vecs [8];
    beat_t sb [$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every forwarded beat must match the oldest expected one.
    always @(negedge ACLK) begin
        if (beat_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL beat_unexpected: got data %0h idx %0h, expected no beat (t=%0t)",
                         beat_data, beat_idx, $time);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", beat_data, e.data);
                check("beat_idx", beat_idx, e.idx);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_arvalid"}, ARVALID_M, 0);
        check({tag, "_rready"}, RREADY_M, 0);
        check({tag, "_beat_valid"}, beat_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_beat_data"}, beat_data, 0);
        check({tag, "_beat_idx"}, beat_idx, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_araddr"}, ARADDR_M, 0);
        check({tag, "_arlen"}, ARLEN_M, 0);
    endtask

    task automatic run_txn(input vec_t t);
        int n;
        int b;
        int stall_left;
        @(negedge ACLK);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_len   = t.len;
        @(negedge ACLK);
        // Scribble on the request bus: the master must hold its latched copy.
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_len   = 4'hF;
        for (int k = 0; k <= t.ar_wait; k++) begin
            check("arvalid", ARVALID_M, 1);
            check("araddr", ARADDR_M, t.addr);
            check("arlen", ARLEN_M, t.len);
            check("req_ready_busy", req_ready, 0);
            ARREADY_M = (k == t.ar_wait);
            @(negedge ACLK);
        end
        ARREADY_M = 1'b0;
        check("arvalid_drop", ARVALID_M, 0);
        for (int i = 0; i < t.nbeats; i++) begin
            sb.push_back('{t.base + 32'(i), 4'(i)});
        end
        b = 0;
        stall_left = t.stall_cycles;
        while (b < t.nbeats) begin
            RVALID_M   = 1'b1;
            RDATA_M    = t.base + 32'(b);
            RID_M      = (b == t.badid_beat) ? 4'(MASTER_ID + 1) : MASTER_ID;
            RRESP_M    = (b == t.resp_beat) ? t.resp_val : AXI_RESP_OKAY;
            RLAST_M    = (b == t.nbeats - 1);
            beat_stall = (b == t.stall_at) && (stall_left > 0);
            #1;
            check("rready", RREADY_M, !beat_stall);
            if (beat_stall) stall_left--;
            else            b++;
            @(negedge ACLK);
        end
        RVALID_M   = 1'b0;
        RLAST_M    = 1'b0;
        beat_stall = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("done_latency", n, 0);
        check("done_with_beat", beat_valid, 1);
        check("err_code", err_code, t.exp_err);
        #2;
        check("beats_remaining", sb.size(), 0);
        sb.delete();
        @(negedge ACLK);
        check("done_one_cycle", done, 0);
        check("req_ready_after", req_ready, 1);
        check("err_hold", err_code, t.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr          len  arw nb base      rsp_b rsp_val           bad stl  sc  exp
        vecs[0] = '{32'h0000_0100, 4'd3,  2, 4, 32'hA0,   -1, AXI_RESP_OKAY,   -1, -1, 0, 2'b00};
        vecs[1] = '{32'h0000_0200, 4'd1,  0, 2, 32'hB0,   -1, AXI_RESP_OKAY,   -1,  1, 3, 2'b00};
        vecs[2] = '{32'h0000_0300, 4'd0,  0, 1, 32'hC0,    0, AXI_RESP_SLVERR, -1, -1, 0, 2'b01};
        vecs[3] = '{32'h0000_0400, 4'd3,  0, 2, 32'hD0,   -1, AXI_RESP_OKAY,   -1, -1, 0, 2'b10};
        vecs[4] = '{32'h0000_0500, 4'd3,  1, 6, 32'hE0,   -1, AXI_RESP_OKAY,   -1, -1, 0, 2'b10};
        vecs[5] = '{32'h0000_0600, 4'd0,  0, 1, 32'hF0,   -1, AXI_RESP_OKAY,    0, -1, 0, 2'b10};
        vecs[6] = '{32'h0000_0700, 4'd3,  1, 4, 32'h1_00,  2, AXI_RESP_DECERR, -1, -1, 0, 2'b01};
        vecs[7] = '{32'h0000_0800, 4'd15, 0, 16, 32'h2_00, -1, AXI_RESP_OKAY,  -1, -1, 0, 2'b00};

        ARESET     = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        beat_stall = 1'b0;
        ARREADY_M  = 1'b0;
        RID_M      = '0;
        RDATA_M    = '0;
        RRESP_M    = '0;
        RLAST_M    = 1'b0;
        RVALID_M   = 1'b0;
        #2;
        check_reset_outputs("por");
        check("arsize", ARSIZE_M, 3'd2);
        check("arburst", ARBURST_M, 2'b01);
        check("arid", ARID_M, MASTER_ID);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Reset in the middle of a four-beat burst after one beat.
        @(negedge ACLK);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0900;
        req_len   = 4'd3;
        @(negedge ACLK);
        req_valid = 1'b0;
        ARREADY_M = 1'b1;
        @(negedge ACLK);
        ARREADY_M = 1'b0;
        sb.push_back('{32'h3_00, 4'd0});
        RVALID_M = 1'b1;
        RDATA_M  = 32'h3_00;
        RID_M    = MASTER_ID;
        RRESP_M  = AXI_RESP_OKAY;
        RLAST_M  = 1'b0;
        @(negedge ACLK);
        RDATA_M = 32'h3_01;
        #2;
        ARESET = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_first_beat_seen", sb.size(), 0);
        sb.delete();
        @(negedge ACLK);
        RVALID_M = 1'b0;
        ARESET   = 1'b0;
        run_txn('{32'h0000_0A00, 4'd0, 0, 1, 32'h4_00, -1, AXI_RESP_OKAY, -1, -1, 0, 2'b00});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
AXI4 read-channel initiator: the master-side counterpart of the ROM/SRAM slave read FSMs. It accepts a single burst-read request from a core-side client (I-fetch or D-cache refill), drives the AR handshake, then collects R beats and forwards each beat to the client. It sits between a CPU-side memory port and an AXI bridge master port. One outstanding transaction at a time.

Parameters:
ID_BITS, 4, width of ARID/RID
ADDR_BITS, 32, address width
DATA_BITS, 32, data width per beat
LEN_BITS, 4, ARLEN width (burst = len+1 beats)
MASTER_ID, 0, constant driven on ARID_M and expected on RID_M

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
req_valid  in  1  client read request
req_ready  out  1  master idle, request can be accepted
req_addr  in  ADDR_BITS  burst start address
req_len  in  LEN_BITS  beats minus one
beat_stall  in  1  client cannot take a beat this cycle
beat_valid  out  1  registered beat strobe
beat_data  out  DATA_BITS  registered beat data
beat_idx  out  LEN_BITS  index of the beat on beat_data
done  out  1  one-cycle pulse at end of transaction
err_code  out  2  [0] SLVERR/DECERR seen, [1] protocol error; valid with done
ARID_M  out  ID_BITS  = MASTER_ID
ARADDR_M  out  ADDR_BITS  latched req_addr
ARLEN_M  out  LEN_BITS  latched req_len
ARSIZE_M  out  3  log2(DATA_BITS/8)
ARBURST_M  out  2  INCR (2'b01)
ARVALID_M  out  1  address valid
ARREADY_M  in  1  address ready
RID_M  in  ID_BITS  read ID
RDATA_M  in  DATA_BITS  read data
RRESP_M  in  2  read response
RLAST_M  in  1  last beat
RVALID_M  in  1  data valid
RREADY_M  out  1  data ready

Behaviour:
- States: IDLE, ADDR, DATA, DONE.
- Reset (async, ARESET=1): state IDLE; req_ready=1 (combinational from IDLE); ARVALID_M, RREADY_M, beat_valid, done = 0; beat_data, beat_idx, err_code, latched addr/len, beat counter = 0.
- IDLE: req_ready=1. On req_valid: latch addr/len, clear err_code and counter, go ADDR next cycle. Inputs are ignored outside IDLE.
- ADDR: ARVALID_M=1. ARADDR_M and ARLEN_M stay stable until the handshake. On ARREADY_M, go DATA next cycle. ARVALID_M is never withdrawn before ARREADY_M.
- DATA: RREADY_M = ~beat_stall. A handshake is RVALID_M & RREADY_M.
- Per handshake, next cycle: beat_valid=1, beat_data=RDATA_M, beat_idx=counter. The counter then increments and wraps at 2^LEN_BITS.
- beat_valid is low in every cycle without a handshake.
- RRESP_M[1]=1 on any beat sets err_code[0] (sticky).
- RID_M != MASTER_ID on any beat sets err_code[1]; the beat is still forwarded.
- RLAST_M on a beat with counter != latched len sets err_code[1].
- Counter == len with RLAST_M=0 sets err_code[1]; beats continue to be accepted until RLAST_M.
- Termination occurs only on an RLAST_M handshake: go DONE.
- DONE: done=1 for exactly one cycle, err_code holds final value, then IDLE. The last beat_valid coincides with done. req_ready rises the cycle after DONE.
- Latency, single beat with a zero-wait slave: req accept (cycle 0) -> ARVALID_M (1) -> R handshake (2) -> beat_valid+done (3) -> req_ready (4).
- err_code holds until the next request is accepted.
- Reset mid-transaction: immediate return to IDLE, no done pulse, all outputs to reset values.

Decomposition:
- Shared package axi_master_pkg: state enum (IDLE/ADDR/DATA/DONE), AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, err_code bit indices.
- ID/len widths come from the existing AXI defines header.
- Sub-module axi_beat_tracker holds the beat counter, last/overrun/underrun compare and sticky err_code. The top keeps the FSM and the AR/R ports.

Test Plan:
1. req_addr=0x100, req_len=3, slave ARREADY after 2 cycles, 4 beats 0xA0..0xA3 with RLAST on 4th -> ARVALID_M held 3 cycles with ARADDR_M=0x100, ARLEN_M=3; beat_idx 0..3 with data 0xA0..0xA3; done with err_code=0.
2. len=1, beat_stall high for 3 cycles mid-burst with RVALID_M held -> RREADY_M low during stall, no duplicate or lost beat, 2 beats delivered.
3. len=0, RRESP_M=SLVERR -> one beat delivered, done with err_code=2'b01.
4. len=3, RLAST_M asserted on 2nd beat -> done after 2 beats, err_code=2'b10. Repeat with RLAST on 6th beat -> 6 beats delivered, err_code=2'b10.
5. RID_M=MASTER_ID+1 on beat 0 of len=0 -> beat forwarded, err_code=2'b10.
6. ARESET pulsed in DATA after 1 of 4 beats -> all outputs 0, req_ready=1. A new request len=0 then completes cleanly with err_code=0.
